axis_pkt_fifo: RTL and testbench

Parametrised AXI-Stream FIFO, successor to `fifo_axi`, with `tlast` framing, occupancy and threshold flags, and an optional store-and-forward packet mode. It sits between a streaming producer and consumer on a single `aclk` domain. It buffers up to `FIFO_DEPTH` beats. In packet mode it holds back a frame until its last beat is stored, so downstream never sees an underrun mid-frame.

---
 rtl/axis_pkt_fifo.sv | 130 +++++++++++++
 tb/tb_axis_pkt_fifo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: single-clock AXI-Stream FIFO with tlast framing, occupancy
// and threshold flags, and an optional store-and-forward packet mode that
// holds a frame back until its last beat is stored. A frame that does not
// fit in the FIFO is released early and flagged with pkt_oversize.
module axis_pkt_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int AF_THRESH   = 12,
    parameter int AE_THRESH   = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_last,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          pkt_oversize
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0] rd_word;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       pkt_count;
    logic [CW-1:0]       count_next;
    logic [CW-1:0]       pkt_next;
    logic                s_ready_q;
    logic                rel_q;
    logic                rel_next;
    logic                oversize_next;
    logic                wr_en;
    logic                rd_en;
    logic                wr_eop;
    logic                rd_eop;

    // No writes are accepted while reset is held, even if the registered
    // ready was still high from before reset.
    assign s_ready = s_ready_q && !areset;
    assign wr_en   = s_valid && s_ready;
    assign rd_en   = m_valid && m_ready;
    assign wr_eop  = wr_en && s_last;
    assign rd_eop  = rd_en && m_last;

    // First-word fall-through: the head entry is always presented.
    assign rd_word = mem[rd_ptr];
    assign m_data  = rd_word[DATA_WIDTH-1:0];
    assign m_last  = rd_word[DATA_WIDTH];

    // In packet mode the head is only offered once a complete frame is
    // stored, or once an oversize frame has been force-released.
    assign m_valid = (count != '0) && ((PACKET_MODE == 0) || (pkt_count != '0) || rel_q);

    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Next-state for occupancy, frame count and the oversize release flag.
    always_comb begin
        count_next    = count;
        pkt_next      = pkt_count;
        rel_next      = rel_q;
        oversize_next = 1'b0;
        if (wr_en && !rd_en) begin
            count_next = count + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_next = count - CW'(1);
        end
        if (PACKET_MODE != 0) begin
            if (wr_eop && !rd_eop) begin
                pkt_next = pkt_count + CW'(1);
            end else if (rd_eop && !wr_eop) begin
                pkt_next = pkt_count - CW'(1);
            end
            // A full FIFO with no complete frame can never make progress,
            // so the partial frame is let through cut-through style.
            if (rd_eop) begin
                rel_next = 1'b0;
            end else if (!rel_q && (count_next == DEPTH_C) && (pkt_next == '0)) begin
                rel_next      = 1'b1;
                oversize_next = 1'b1;
            end
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pkt_count    <= '0;
            rel_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            pkt_oversize <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next;
            pkt_count    <= pkt_next;
            rel_q        <= rel_next;
            s_ready_q    <= (count_next < DEPTH_C);
            pkt_oversize <= oversize_next;
        end
    end

    // Storage array; contents are not cleared by reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_last, s_data};
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: scoreboard bench for axis_pkt_fifo, one cut-through and
// one store-and-forward instance, checked against a queue-based model.
module tb_axis_pkt_fifo;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;

    logic [31:0] s_data0 = '0, m_data0, s_data1 = '0, m_data1;
    logic        s_last0 = 0, s_valid0 = 0, s_ready0, m_last0, m_valid0, m_ready0 = 0;
    logic        s_last1 = 0, s_valid1 = 0, s_ready1, m_last1, m_valid1, m_ready1 = 0;
    logic [4:0]  count0, count1;
    logic        af0, ae0, ovs0, af1, ae1, ovs1_dut;

    int          errors = 0;
    int          checks = 0;
    int          ovs_seen = 0;
    int          ovs_before;
    int          sent;
    logic        acc;
    logic        v;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic        rdy0 = 0, rdy1 = 0, rel1 = 0, ovs1 = 0, model_ok = 0;
    logic [32:0] mb;
    logic        mv;

    axis_pkt_fifo #(.PACKET_MODE(0)) u_ct (
        .aclk(aclk), .areset(areset),
        .s_data(s_data0), .s_last(s_last0), .s_valid(s_valid0), .s_ready(s_ready0),
        .m_data(m_data0), .m_last(m_last0), .m_valid(m_valid0), .m_ready(m_ready0),
        .count(count0), .almost_full(af0), .almost_empty(ae0), .pkt_oversize(ovs0)
    );

    axis_pkt_fifo #(.PACKET_MODE(1)) u_pk (
        .aclk(aclk), .areset(areset),
        .s_data(s_data1), .s_last(s_last1), .s_valid(s_valid1), .s_ready(s_ready1),
        .m_data(m_data1), .m_last(m_last1), .m_valid(m_valid1), .m_ready(m_ready1),
        .count(count1), .almost_full(af1), .almost_empty(ae1), .pkt_oversize(ovs1_dut)
    );

    initial forever #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lasts1();
        int n = 0;
        foreach (q1[i]) n += int'(q1[i][32]);
        return n;
    endfunction

    function automatic logic valid1();
        return (q1.size() != 0) && ((lasts1() != 0) || rel1);
    endfunction

    // Reference model: a beat queue per instance, a registered-ready copy,
    // and for packet mode the release flag and expected oversize pulse.
    initial forever begin
        @(posedge aclk);
        if (areset) begin
            q0.delete();
            q1.delete();
            rdy0 = 0; rdy1 = 0; rel1 = 0; ovs1 = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if ((q0.size() != 0) && m_ready0) void'(q0.pop_front());
            if (s_valid0 && rdy0) q0.push_back({s_last0, s_data0});
            rdy0 = (q0.size() < 16);
            mv = valid1();
            ovs1 = 0;
            if (mv && m_ready1) begin
                mb = q1.pop_front();
                if (mb[32]) rel1 = 0;
            end
            if (s_valid1 && rdy1) q1.push_back({s_last1, s_data1});
            rdy1 = (q1.size() < 16);
            if ((q1.size() == 16) && (lasts1() == 0) && !rel1) begin
                rel1 = 1;
                ovs1 = 1;
            end
        end
    end

    // Monitor: compares every output against the model away from the edge.
    initial forever begin
        @(negedge aclk);
        if (model_ok) begin
            check_output("ct_count",   64'(count0),   64'(q0.size()));
            check_output("ct_s_ready", 64'(s_ready0), 64'(rdy0 && !areset));
            check_output("ct_m_valid", 64'(m_valid0), 64'(q0.size() != 0));
            check_output("ct_af",      64'(af0),      64'(q0.size() >= 12));
            check_output("ct_ae",      64'(ae0),      64'(q0.size() <= 4));
            check_output("ct_ovs",     64'(ovs0),     64'(0));
            if (q0.size() != 0) check_output("ct_data", 64'({m_last0, m_data0}), 64'(q0[0]));
            check_output("pk_count",   64'(count1),   64'(q1.size()));
            check_output("pk_s_ready", 64'(s_ready1), 64'(rdy1 && !areset));
            check_output("pk_m_valid", 64'(m_valid1), 64'(valid1()));
            check_output("pk_af",      64'(af1),      64'(q1.size() >= 12));
            check_output("pk_ae",      64'(ae1),      64'(q1.size() <= 4));
            check_output("pk_ovs",     64'(ovs1_dut), 64'(ovs1));
            if (valid1()) check_output("pk_data", 64'({m_last1, m_data1}), 64'(q1[0]));
            if (ovs1_dut) ovs_seen++;
        end
    end

    // Drives one cycle of inputs on instance d; acc reports a write handshake.
    task automatic apply_stimulus(input int d, input logic vv, input logic [31:0] data,
                                  input logic last, input logic mr, output logic hs);
        if (d == 0) begin
            s_valid0 = vv; s_data0 = data; s_last0 = last; m_ready0 = mr;
            s_valid1 = 0;  m_ready1 = 0;
        end else begin
            s_valid1 = vv; s_data1 = data; s_last1 = last; m_ready1 = mr;
            s_valid0 = 0;  m_ready0 = 0;
        end
        @(negedge aclk);
        hs = (d == 0) ? (s_valid0 && s_ready0) : (s_valid1 && s_ready1);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        // Reset state
        areset = 1;
        apply_stimulus(0, 0, 0, 0, 0, acc);
        apply_stimulus(0, 0, 0, 0, 0, acc);
        check_output("rst_count",   64'(count0),   64'(0));
        check_output("rst_s_ready", 64'(s_ready0), 64'(0));
        check_output("rst_m_valid", 64'(m_valid0), 64'(0));
        check_output("rst_af",      64'(af0),      64'(0));
        check_output("rst_ae",      64'(ae0),      64'(1));
        check_output("rst_pk_ovs",  64'(ovs1_dut), 64'(0));
        areset = 0;

        // Fill with 0x0..0xF, no reads
        sent = 0;
        for (int c = 0; c < 100 && sent < 16; c++) begin
            apply_stimulus(0, 1, 32'(sent), sent == 15, 0, acc);
            if (acc) sent++;
        end
        check_output("fill_sent",    64'(sent),     64'(16));
        check_output("full_count",   64'(count0),   64'(16));
        check_output("full_s_ready", 64'(s_ready0), 64'(0));
        check_output("full_af",      64'(af0),      64'(1));

        // Drain all 16 in order
        for (int i = 0; i < 16; i++) apply_stimulus(0, 0, 0, 0, 1, acc);
        check_output("drain_m_valid", 64'(m_valid0), 64'(0));
        check_output("drain_ae",      64'(ae0),      64'(1));

        // Full FIFO with simultaneous read and write: only the read happens
        sent = 0;
        for (int c = 0; c < 100 && sent < 16; c++) begin
            apply_stimulus(0, 1, 32'h100 + 32'(sent), 0, 0, acc);
            if (acc) sent++;
        end
        apply_stimulus(0, 1, 32'hDEAD, 0, 1, acc);
        check_output("full_rw_no_write", 64'(acc),      64'(0));
        check_output("full_rw_count",    64'(count0),   64'(15));
        check_output("full_rw_s_ready",  64'(s_ready0), 64'(1));
        for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 0, 1, acc);

        // Random streaming of 40 beats with random back-pressure
        sent = 0;
        for (int c = 0; c < 600 && (sent < 40 || q0.size() != 0); c++) begin
            v = (sent < 40) && (($urandom % 4) != 0);
            apply_stimulus(0, v, $urandom, 1'($urandom % 2), 1'($urandom % 2), acc);
            if (acc) sent++;
        end
        check_output("rand_sent",  64'(sent),   64'(40));
        check_output("rand_count", 64'(count0), 64'(0));

        // Reset with 7 beats stored
        for (int i = 0; i < 7; i++) apply_stimulus(0, 1, 32'h70 + 32'(i), 0, 0, acc);
        check_output("pre_rst_count", 64'(count0), 64'(7));
        areset = 1;
        apply_stimulus(0, 0, 0, 0, 0, acc);
        areset = 0;
        check_output("mid_rst_count",   64'(count0),   64'(0));
        check_output("mid_rst_m_valid", 64'(m_valid0), 64'(0));
        check_output("mid_rst_s_ready", 64'(s_ready0), 64'(0));
        apply_stimulus(0, 0, 0, 0, 0, acc);
        check_output("post_rst_s_ready", 64'(s_ready0), 64'(1));
        apply_stimulus(0, 1, 32'h1234_5678, 1, 0, acc);
        check_output("post_rst_accept",  64'(acc),      64'(1));
        check_output("post_rst_m_valid", 64'(m_valid0), 64'(1));
        check_output("post_rst_data",    64'(m_data0),  64'(32'h1234_5678));
        apply_stimulus(0, 0, 0, 0, 1, acc);

        // Packet mode: 5-beat frame held until its last beat is stored
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1, 1, 32'h500 + 32'(i), i == 4, 1, acc);
            check_output("pk5_accept", 64'(acc),      64'(1));
            check_output("pk5_hold",   64'(m_valid1), 64'(i == 4));
        end
        for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 0, 0, 1, acc);
        check_output("pk5_empty", 64'(m_valid1), 64'(0));

        // Packet mode: 20-beat frame forces an oversize release
        ovs_before = ovs_seen;
        sent = 0;
        for (int c = 0; c < 200 && sent < 20; c++) begin
            apply_stimulus(1, 1, 32'h2000 + 32'(sent), sent == 19, 1, acc);
            if (acc) sent++;
        end
        for (int i = 0; i < 30; i++) apply_stimulus(1, 0, 0, 0, 1, acc);
        check_output("big_sent",  64'(sent),                   64'(20));
        check_output("big_pulse", 64'(ovs_seen - ovs_before),  64'(1));
        check_output("big_count", 64'(count1),                 64'(0));

        // Packet mode: random frames with random back-pressure
        sent = 0;
        for (int c = 0; c < 1500 && (sent < 60 || q1.size() != 0); c++) begin
            v = (sent < 60) && (($urandom % 3) != 0);
            apply_stimulus(1, v, $urandom, (sent == 59) || (($urandom % 5) == 0),
                           1'($urandom % 2), acc);
            if (acc) sent++;
        end
        check_output("pk_rand_sent",  64'(sent),   64'(60));
        check_output("pk_rand_count", 64'(count1), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
